alu_pipe: RTL

Registered, handshaked successor to the combinational 4-op ALU: N-bit datapath, 8 operations including signed/unsigned compare and an iterative multiply, plus a full NZCV flag set. Operands enter through a valid/ready port and results leave through a registered valid/ready port, so the block can sit between pipeline stages with back-pressure. Single-cycle ops sustain one result per clock. MUL occupies the unit for N cycles.

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_pipe_mul.sv | 35 +++
 rtl/alu_pipe.sv | 82 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and flag struct shared by alu_pipe and its bench
package alu_pkg;
  typedef enum logic [2:0] {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SLT, OP_SLTU, OP_MUL} alu_op_e;
  typedef enum logic {S_IDLE, S_MUL} alu_state_e;
  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;
endpackage

// File: rtl/alu_pipe_mul.sv
// mul_iter: shift-add multiplier (start loads A/B, step runs one iteration, last_o flags final step, product_o = acc after current step)
module mul_iter #(parameter int N = 64) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         step_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         last_o,
  output logic [N-1:0] product_o
);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0] r_mcand, r_mplr, r_acc;
  logic [CW-1:0] r_cnt;
  assign product_o = r_acc + (r_mplr[0] ? r_mcand : '0);
  assign last_o = r_cnt == CW'(1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mcand <= '0;
      r_mplr <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (start_i) begin
      r_mcand <= a_i;
      r_mplr <= b_i;
      r_acc <= '0;
      r_cnt <= CW'(N);
    end else if (step_i) begin
      r_mcand <= r_mcand << 1;
      r_mplr <= r_mplr >> 1;
      r_acc <= product_o;
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked 8-op ALU (in_valid/in_ready/op/a/b in; out_valid/out_ready/result/NZCV flags out; busy during iterative MUL)
module alu_pipe
  import alu_pkg::*;
#(parameter int N = 64) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [2:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] result_o,
  output logic         zero_o,
  output logic         neg_o,
  output logic         carry_o,
  output logic         ovf_o,
  output logic         busy_o
);
  alu_state_e r_state, w_next;
  alu_op_e w_op;
  alu_flags_t r_flags, w_flags;
  logic [N-1:0] r_result, w_res, w_bop, w_prod;
  logic [N:0] w_sum;
  logic r_valid, w_acc, w_start, w_sub, w_ovf, w_last, w_wr;
  assign w_op = alu_op_e'(op_i);
  assign busy_o = r_state == S_MUL;
  assign in_ready_o = !busy_o && (!r_valid || out_ready_i);
  assign w_acc = in_valid_i && in_ready_o;
  assign w_start = w_acc && w_op == OP_MUL;
  assign w_sub = w_op inside {OP_SUB, OP_SLT, OP_SLTU};
  assign w_bop = w_sub ? ~b_i : b_i;
  assign w_sum = {1'b0, a_i} + {1'b0, w_bop} + {{N{1'b0}}, w_sub};
  assign w_ovf = (a_i[N-1] == w_bop[N-1]) && (w_sum[N-1] != a_i[N-1]);
  assign w_wr = (w_acc && !w_start) || (busy_o && w_last);
  assign out_valid_o = r_valid;
  assign result_o = r_result;
  assign {zero_o, neg_o, carry_o, ovf_o} = r_flags;
  mul_iter #(.N(N)) u_mul (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(w_start), .step_i(busy_o),
    .a_i(a_i), .b_i(b_i), .last_o(w_last), .product_o(w_prod)
  );
  always_comb begin
    w_res = '0;
    w_flags = '0;
    if (busy_o) w_res = w_prod;
    else begin
      case (w_op)
        OP_AND: w_res = a_i & b_i;
        OP_OR: w_res = a_i | b_i;
        OP_XOR: w_res = a_i ^ b_i;
        OP_ADD, OP_SUB: begin
          w_res = w_sum[N-1:0];
          w_flags.carry = w_sum[N];
          w_flags.ovf = w_ovf;
        end
        OP_SLT: w_res = {{(N-1){1'b0}}, w_sum[N-1] ^ w_ovf};
        OP_SLTU: w_res = {{(N-1){1'b0}}, !w_sum[N]};
        default: w_res = '0;
      endcase
    end
    w_flags.zero = w_res == '0;
    w_flags.neg = w_res[N-1];
  end
  always_comb w_next = busy_o ? (w_last ? S_IDLE : S_MUL) : (w_start ? S_MUL : S_IDLE);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_result <= '0;
      r_flags <= '0;
    end else if (w_wr) begin
      r_valid <= 1'b1;
      r_result <= w_res;
      r_flags <= w_flags;
    end else if (out_ready_i) r_valid <= 1'b0;
  end
endmodule
